// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the boot-time SRAM loader.
// Holds the FSM state encoding, byte-lane masks and frame header size.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_WR   = 3'd2,
    S_GAP  = 3'd3,
    S_FIN  = 3'd4,
    S_CHK  = 3'd5,
    S_DONE = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

  localparam logic [3:0] LANE_MASK_1 = 4'b0001;
  localparam logic [3:0] LANE_MASK_2 = 4'b0011;
  localparam logic [3:0] LANE_MASK_3 = 4'b0111;
  localparam logic [3:0] LANE_MASK_4 = 4'b1111;

  // Write strobe for a word holding n bytes in lanes 0..n-1.
  function automatic logic [3:0] lane_mask(input logic [2:0] n);
    case (n)
      3'd1:    return LANE_MASK_1;
      3'd2:    return LANE_MASK_2;
      3'd3:    return LANE_MASK_3;
      3'd4:    return LANE_MASK_4;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Byte-stream input and native SRAM write bus of the loader.
// master = loader side (stream sink, bus requester); slave = stream source and SRAM.
interface mem_loader_if;

  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;

  logic        mem_sel;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;

  modport master (
    input  in_valid, in_data, mem_ready,
    output in_ready, mem_sel, mem_addr, mem_wstrb, mem_wdata
  );

  modport slave (
    output in_valid, in_data, mem_ready,
    input  in_ready, mem_sel, mem_addr, mem_wstrb, mem_wdata
  );

endinterface

// File: rtl/mem_loader_byte_packer.sv
// Packs bytes little-endian into a 32-bit word: byte k of a word lands in lane k.
// Word and lane mask are valid the cycle after a push; clr empties it for the next word.
module byte_packer
  import mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic [3:0]  mask,
  output logic        last_lane
);

  logic [2:0]  cnt_q;
  logic [31:0] buf_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      buf_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
      buf_q <= '0;
    end else if (push) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        if (cnt_q == 3'(k)) buf_q[8*k +: 8] <= din;
      end
      cnt_q <= cnt_q + 3'd1;
    end
  end

  assign word      = buf_q;
  assign mask      = lane_mask(cnt_q);
  // The next push fills the top lane and completes the word.
  assign last_lane = (cnt_q == 3'(WORD_BYTES - 1));

endmodule

// File: rtl/mem_loader.sv
// Boot loader: length-prefixed byte stream -> 32-bit SRAM writes, CPU held in reset until done.
// One byte/cycle in DATA, >=2 cycles per word write; MEM_LOADER_CHECKSUM_EN adds a trailing XOR byte.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_BYTES = 65536
) (
  input  logic         clk,
  input  logic         resetn,
  mem_loader_if.master bus,
  output logic         cpu_resetn,
  output logic         done,
  output logic         error
);

  state_t      state_q, state_d;
  logic        live_q;
  logic [1:0]  hdr_cnt_q;
  logic [23:0] len_q;
  logic [31:0] len_full;
  logic [31:0] rem_q;
  logic [31:0] addr_q;

  logic        in_ready_c;
  logic        mem_sel_c;
  logic [3:0]  mem_wstrb_c;
  logic        accept;

  logic        pk_clr;
  logic        pk_push;
  logic [31:0] pk_word;
  logic [3:0]  pk_mask;
  logic        pk_last;

  assign accept   = bus.in_valid && in_ready_c;
  // Header arrives LSB first; the fourth byte completes the length.
  assign len_full = {bus.in_data, len_q};

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      csum_q <= '0;
    else if (pk_push) csum_q <= csum_q ^ bus.in_data;
  end
`endif

  byte_packer u_packer (
    .clk       (clk),
    .resetn    (resetn),
    .clr       (pk_clr),
    .push      (pk_push),
    .din       (bus.in_data),
    .word      (pk_word),
    .mask      (pk_mask),
    .last_lane (pk_last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_LEN;
      live_q    <= 1'b0;
      hdr_cnt_q <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      addr_q    <= BASE_ADDR;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (state_q == S_LEN && accept) begin
        len_q     <= len_full[31:8];
        hdr_cnt_q <= hdr_cnt_q + 2'd1;
        if (hdr_cnt_q == 2'(HDR_BYTES - 1)) rem_q <= len_full;
      end
      if (pk_push) rem_q <= rem_q - 32'd1;
      if (state_q == S_GAP) addr_q <= addr_q + 32'd4;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    mem_sel_c   = 1'b0;
    mem_wstrb_c = 4'b0000;
    pk_push     = 1'b0;
    pk_clr      = 1'b0;
    cpu_resetn  = 1'b0;
    done        = 1'b0;
    error       = 1'b0;

    case (state_q)
      S_LEN: begin
        // live_q keeps in_ready low through reset and the first cycle after it.
        in_ready_c = live_q;
        if (accept && hdr_cnt_q == 2'(HDR_BYTES - 1)) begin
          if (len_full > 32'(MAX_BYTES)) state_d = S_ERR;
          else if (len_full == 32'd0)    state_d = S_FIN;
          else                           state_d = S_DATA;
        end
      end
      S_DATA: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          pk_push = 1'b1;
          if (pk_last || rem_q == 32'd1) state_d = S_WR;
        end
      end
      S_WR: begin
        mem_sel_c   = 1'b1;
        mem_wstrb_c = pk_mask;
        if (bus.mem_ready) state_d = S_GAP;
      end
      S_GAP: begin
        // Registered SRAM ready is still high here; sel stays low so it cannot complete a new request.
        pk_clr  = 1'b1;
        state_d = (rem_q == 32'd0) ? S_FIN : S_DATA;
      end
      S_FIN: begin
`ifdef MEM_LOADER_CHECKSUM_EN
        state_d = S_CHK;
`else
        state_d = S_DONE;
`endif
      end
      S_CHK: begin
`ifdef MEM_LOADER_CHECKSUM_EN
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
`else
        state_d = S_ERR;
`endif
      end
      S_DONE: begin
        done       = 1'b1;
        cpu_resetn = 1'b1;
      end
      S_ERR: begin
        error = 1'b1;
      end
      default: state_d = S_ERR;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.mem_sel   = mem_sel_c;
  assign bus.mem_wstrb = mem_wstrb_c;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = pk_word;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: directed frames in, expected SRAM writes queued and checked by a bus monitor.
module tb_mem_loader;

  typedef logic [7:0] bq_t[$];

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic clk = 1'b0;
  logic resetn;
  logic cpu_resetn, done, error;

  int checks   = 0;
  int failures = 0;
  int sel_cycles = 0;
  wr_t exp_q[$];
  bit  prev_cpl = 1'b0;

  mem_loader_if bus ();

  mem_loader #(
    .BASE_ADDR (32'h0000_0000),
    .MAX_BYTES (65536)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .cpu_resetn (cpu_resetn),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // SRAM with registered ready: answers one cycle after it sees sel.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) bus.mem_ready <= 1'b0;
    else         bus.mem_ready <= bus.mem_sel;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t w;
    w.addr = a;
    w.data = d;
    w.strb = s;
    exp_q.push_back(w);
  endtask

  // Bus monitor: compares every sel cycle against the head expectation, pops on completion.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_cpl = 1'b0;
    end else begin
      if (prev_cpl) chk("gap_after_write", {31'd0, bus.mem_sel}, 32'd0);
      if (bus.mem_sel) begin
        sel_cycles++;
        if (exp_q.size() > 0) begin
          chk("wr_addr", bus.mem_addr, exp_q[0].addr);
          chk("wr_data", bus.mem_wdata, exp_q[0].data);
          chk("wr_strb", {28'd0, bus.mem_wstrb}, {28'd0, exp_q[0].strb});
          if (bus.mem_ready) void'(exp_q.pop_front());
        end else if (bus.mem_ready) begin
          chk("unexpected_write", bus.mem_addr, 32'hFFFF_FFFF);
        end
      end
      prev_cpl = bus.mem_sel && bus.mem_ready;
    end
  end

  function automatic bq_t mk_frame(input logic [31:0] len, input bq_t pl);
    bq_t f;
    f = {len[7:0], len[15:8], len[23:16], len[31:24]};
    foreach (pl[i]) f.push_back(pl[i]);
`ifdef MEM_LOADER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      foreach (pl[i]) x = x ^ pl[i];
      f.push_back(x);
    end
`endif
    return f;
  endfunction

  // Caller is in the posedge+1 phase; returns in the same phase after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int  n;
    bit  acc;
    if (gaps && $urandom_range(0, 1) == 1) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    forever begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 500) begin
        checks++;
        failures++;
        $display("FAIL send_byte_timeout: byte %h not accepted, in_ready=%b", b, bus.in_ready);
        break;
      end
    end
  endtask

  task automatic send_raw(input bq_t f, input bit gaps);
    foreach (f[i]) send_byte(f[i], gaps);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (!done && !error && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done && !error) begin
      checks++;
      failures++;
      $display("FAIL wait_end_timeout: done=%b error=%b required one of them high", done, error);
    end
  endtask

  task automatic do_reset(input bit check);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    if (check) begin
      chk("rst_in_ready",   {31'd0, bus.in_ready}, 32'd0);
      chk("rst_mem_sel",    {31'd0, bus.mem_sel}, 32'd0);
      chk("rst_mem_addr",   bus.mem_addr, 32'h0000_0000);
      chk("rst_mem_wstrb",  {28'd0, bus.mem_wstrb}, 32'd0);
      chk("rst_mem_wdata",  bus.mem_wdata, 32'd0);
      chk("rst_cpu_resetn", {31'd0, cpu_resetn}, 32'd0);
      chk("rst_done",       {31'd0, done}, 32'd0);
      chk("rst_error",      {31'd0, error}, 32'd0);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bq_t pl8, pl5, empty, hdr;
    int  s0;

    pl8 = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    pl5 = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    resetn = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    do_reset(1'b1);

    // Two full words.
    exp_push(32'h0, 32'h1413_1211, 4'hF);
    exp_push(32'h4, 32'h1817_1615, 4'hF);
    send_raw(mk_frame(32'd8, pl8), 1'b0);
    wait_end();
    chk("l8_done",       {31'd0, done}, 32'd1);
    chk("l8_cpu_resetn", {31'd0, cpu_resetn}, 32'd1);
    chk("l8_error",      {31'd0, error}, 32'd0);
    chk("l8_writes_left", exp_q.size(), 32'd0);

    // Partial tail word.
    do_reset(1'b0);
    exp_push(32'h0, 32'hDDCC_BBAA, 4'hF);
    exp_push(32'h4, 32'h0000_00EE, 4'b0001);
    send_raw(mk_frame(32'd5, pl5), 1'b0);
    wait_end();
    chk("l5_done", {31'd0, done}, 32'd1);
    chk("l5_writes_left", exp_q.size(), 32'd0);

    // Empty image: no bus activity, done shortly after the header.
    do_reset(1'b0);
    s0 = sel_cycles;
    send_raw(mk_frame(32'd0, empty), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("l0_done",       {31'd0, done}, 32'd1);
    chk("l0_cpu_resetn", {31'd0, cpu_resetn}, 32'd1);
    chk("l0_no_sel",     sel_cycles, s0);

    // Same image as the first frame with in_valid toggling.
    do_reset(1'b0);
    exp_push(32'h0, 32'h1413_1211, 4'hF);
    exp_push(32'h4, 32'h1817_1615, 4'hF);
    send_raw(mk_frame(32'd8, pl8), 1'b1);
    wait_end();
    chk("gaps_done", {31'd0, done}, 32'd1);
    chk("gaps_writes_left", exp_q.size(), 32'd0);

    // L == MAX_BYTES is accepted into DATA.
    do_reset(1'b0);
    hdr = {8'h00, 8'h00, 8'h01, 8'h00};
    send_raw(hdr, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("max_error",    {31'd0, error}, 32'd0);
    chk("max_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // L == MAX_BYTES + 1 is rejected.
    do_reset(1'b0);
    s0 = sel_cycles;
    hdr = {8'h01, 8'h00, 8'h01, 8'h00};
    send_raw(hdr, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("over_error",      {31'd0, error}, 32'd1);
    chk("over_cpu_resetn", {31'd0, cpu_resetn}, 32'd0);
    chk("over_done",       {31'd0, done}, 32'd0);
    chk("over_in_ready",   {31'd0, bus.in_ready}, 32'd0);
    chk("over_no_sel",     sel_cycles, s0);

`ifdef MEM_LOADER_CHECKSUM_EN
    do_reset(1'b0);
    exp_push(32'h0, 32'h0000_0201, 4'b0011);
    hdr = {8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03};
    send_raw(hdr, 1'b0);
    wait_end();
    chk("csum_ok_done",  {31'd0, done}, 32'd1);
    chk("csum_ok_error", {31'd0, error}, 32'd0);

    do_reset(1'b0);
    exp_push(32'h0, 32'h0000_0201, 4'b0011);
    hdr = {8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h04};
    send_raw(hdr, 1'b0);
    wait_end();
    chk("csum_bad_error",      {31'd0, error}, 32'd1);
    chk("csum_bad_cpu_resetn", {31'd0, cpu_resetn}, 32'd0);
`endif

    // Reset while a write is pending, then a fresh load from BASE_ADDR.
    do_reset(1'b0);
    hdr = {8'h08, 8'h00, 8'h00, 8'h00, 8'h11, 8'h12, 8'h13, 8'h14};
    send_raw(hdr, 1'b0);
    chk("abort_in_wr", {31'd0, bus.mem_sel}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("abort_sel",        {31'd0, bus.mem_sel}, 32'd0);
    chk("abort_cpu_resetn", {31'd0, cpu_resetn}, 32'd0);
    chk("abort_addr",       bus.mem_addr, 32'h0000_0000);
    do_reset(1'b0);
    exp_push(32'h0, 32'hDDCC_BBAA, 4'hF);
    exp_push(32'h4, 32'h0000_00EE, 4'b0001);
    send_raw(mk_frame(32'd5, pl5), 1'b0);
    wait_end();
    chk("reload_done", {31'd0, done}, 32'd1);
    chk("reload_writes_left", exp_q.size(), 32'd0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Boot-time bus master in front of the on-chip SRAM.
- Consumes a byte stream (e.g. from a UART receiver) and packs bytes little-endian into 32-bit words.
- Writes each word to SRAM over the native memory bus (sel/addr/wstrb/wdata/ready), holding the CPU in reset until the image is fully written.
- Output bus is muxed onto the SRAM port while cpu_resetn is low.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be 4-byte aligned.
- MAX_BYTES, 65536, largest accepted image length; a larger header length is an error.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- in_valid  in  1  byte available
- in_data  in  8  byte value
- in_ready  out  1  byte accepted when in_valid && in_ready
- mem_sel  out  1  bus request
- mem_addr  out  32  byte address, word aligned
- mem_wstrb  out  4  byte-lane write enables
- mem_wdata  out  32  write data
- mem_ready  in  1  SRAM completion, registered (one cycle after sel)
- cpu_resetn  out  1  CPU reset release, active-low
- done  out  1  image loaded
- error  out  1  load failed (sticky)

Behaviour:
- Reset, clk and resetn: resetn is asynchronous, active-low; clock clk.
- Reset values: in_ready=0, mem_sel=0, mem_addr=BASE_ADDR, mem_wstrb=0, mem_wdata=0, cpu_resetn=0, done=0, error=0. Reset mid-load abandons it; SRAM contents are undefined.
- Frame format: 4-byte length L (little-endian), then L payload bytes, then a checksum byte (only with the optional feature).
- States:
  - LEN: in_ready=1; shift in 4 bytes. Then L>MAX_BYTES -> ERR; L==0 -> FIN; else DATA.
  - DATA: in_ready=1. Byte k of the current word goes to lane k. Word completes after 4 bytes or the last payload byte; then go to WR with in_ready=0.
  - WR: mem_sel=1; mem_wstrb = mask of filled lanes (4'b1111 for full words; 4'b0001/0011/0111 for a partial tail); mem_addr/wdata held stable. On mem_ready=1, drop mem_sel the same cycle and go to GAP.
  - GAP: one idle cycle with sel=0. Required because SRAM ready is registered and would otherwise falsely complete the next request. Then mem_addr+=4, clear word buffer; go to DATA if bytes remain, else FIN.
  - FIN: go to CHK if the feature is enabled, else DONE.
  - DONE: done=1, cpu_resetn=1, in_ready=0, mem_sel=0. Terminal until reset.
  - ERR: error=1, cpu_resetn=0, in_ready=0. Terminal until reset.
- Remaining-byte counter: 32 bits, decremented per accepted payload byte. Last byte when counter==1.
- Stalls:
  - in_valid low: state holds, no timeout.
  - mem_ready never asserts: hang in WR, no timeout.
- Throughput: one byte per cycle in DATA; each word costs 2+ cycles (WR with one-cycle SRAM + GAP).
- Address wrap: mem_addr is a plain 32-bit add; MAX_BYTES bounds it in practice.

Optional Feature:
- Macro: MEM_LOADER_CHECKSUM_EN.
- Defined:
  - One trailing byte follows the payload, equal to the XOR of all payload bytes (length bytes excluded; L==0 gives 8'h00).
  - In CHK, in_ready=1; accept the byte. Match -> DONE, mismatch -> ERR.
- Undefined: no trailing byte; FIN -> DONE directly; the XOR register is absent.

Decomposition:
- Package mem_loader_pkg:
  - state enum (LEN, DATA, WR, GAP, FIN, CHK, DONE, ERR);
  - lane-mask constants for tail sizes 1..4;
  - header byte count constant 4.
- One natural sub-module: byte_packer (byte-lane counter plus 32-bit shift buffer with valid-lane mask).
- The FSM, address and length counters stay in the top level.

Test Plan:
- L=8, bytes 11..18 -> two writes: addr 0x0 wdata 32'h14131211 wstrb 4'hF; addr 0x4 wdata 32'h18171615 wstrb 4'hF. Then done=1, cpu_resetn=1.
- L=5, bytes AA BB CC DD EE -> second write addr 0x4 wdata 32'h000000EE wstrb 4'b0001.
- L=0 -> no mem_sel pulse ever; done=1 within 2 cycles of the last header byte.
- SRAM model with registered ready, in_valid held high -> mem_sel low for ≥1 cycle between writes; no write issued twice to different addresses. Also in_valid toggled randomly -> same memory image.
- L=MAX_BYTES+1 -> error=1, cpu_resetn=0, no writes. With MEM_LOADER_CHECKSUM_EN: L=2, bytes 01 02, checksum 03 -> done=1; checksum 04 -> error=1.
- resetn pulsed low while in WR -> mem_sel=0 and cpu_resetn=0 immediately; new frame after release loads correctly from BASE_ADDR.
